// File: rtl/i2c_ram_pkg.sv
// Shared definitions for the I2C/menu RAM arbiter: default widths, FSM encoding
// and requester IDs.
package i2c_ram_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_CLEAR     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_I2C   = 2'd1,
    REQ_MENU  = 2'd2,
    REQ_CLEAR = 2'd3
  } req_id_e;

endpackage

// File: rtl/i2c_ram_arb_select.sv
// Priority pick (clear > I2C > menu, menu forced after MENU_MAX_WAIT I2C wins)
// and the registered menu starvation counter.
module i2c_ram_arb_select
  import i2c_ram_pkg::*;
#(
  parameter int MENU_MAX_WAIT = 4,
  parameter int CW            = $clog2(MENU_MAX_WAIT + 1)
)(
  input  logic    clk,
  input  logic    reset,
  input  logic    arb_en,
  input  logic    i2c_req,
  input  logic    menu_req,
  input  logic    clear_pend,
  output logic    grant_valid,
  output req_id_e grant_id
);

  logic [CW-1:0] starve_q, starve_d;
  logic          starve_max;

  assign starve_max = (starve_q == MENU_MAX_WAIT[CW-1:0]);

  always_comb begin
    grant_id = REQ_NONE;
    if (clear_pend)                  grant_id = REQ_CLEAR;
    else if (menu_req && starve_max) grant_id = REQ_MENU;
    else if (i2c_req)                grant_id = REQ_I2C;
    else if (menu_req)               grant_id = REQ_MENU;
    grant_valid = arb_en && (grant_id != REQ_NONE);
  end

  // Counts I2C wins that overtook a waiting menu request; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!menu_req)
      starve_d = '0;
    else if (grant_valid && grant_id == REQ_MENU)
      starve_d = '0;
    else if (grant_valid && grant_id == REQ_I2C && !starve_max)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: rtl/i2c_ram_arbiter.sv
// Two-requester arbiter for a shared single-port RAM, with optional whole-RAM
// clear sweep enabled by defining RAM_ARB_CLEAR_EN.
// Handshake: a side holds req and its fields until ack; ack pulses one cycle in
// ACCESS, a read's rvalid pulses two cycles later; req still high after ack is a new request.
module i2c_ram_arbiter
  import i2c_ram_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MENU_MAX_WAIT = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  output logic              i2c_rvalid,
  input  logic              menu_req,
  input  logic              menu_we,
  input  logic [ADDR_W-1:0] menu_addr,
  input  logic [DATA_W-1:0] menu_wdata,
  output logic              menu_ack,
  output logic [DATA_W-1:0] menu_rdata,
  output logic              menu_rvalid,
`ifdef RAM_ARB_CLEAR_EN
  input  logic              clear_req,
`endif
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  req_id_e           lat_id_q, lat_id_d;
  logic              i2c_rvalid_q, menu_rvalid_q;
  logic [DATA_W-1:0] i2c_rdata_q, menu_rdata_q;
  logic              grant_valid;
  req_id_e           grant_id;
  logic              clr_pend;
  logic              rd_done_i2c, rd_done_menu;

  i2c_ram_arb_select #(.MENU_MAX_WAIT(MENU_MAX_WAIT)) u_select (
    .clk         (clk),
    .reset       (reset),
    .arb_en      (state_q == ST_IDLE),
    .i2c_req     (i2c_req),
    .menu_req    (menu_req),
    .clear_pend  (clr_pend),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef RAM_ARB_CLEAR_EN
  logic              clr_pend_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              clr_last;

  assign clr_last = (state_q == ST_CLEAR) && (clr_addr_q == '1);
  assign clr_pend = clr_pend_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_pend_q <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      if (clr_last)                               clr_pend_q <= 1'b0;
      else if (clear_req && state_q != ST_CLEAR)  clr_pend_q <= 1'b1;
      clr_addr_q <= (state_q == ST_CLEAR) ? clr_addr_q + 1'b1 : '0;
    end
  end
`else
  assign clr_pend = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_id_d    = lat_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          case (grant_id)
            REQ_I2C: begin
              state_d     = ST_ACCESS;
              lat_we_d    = i2c_we;
              lat_addr_d  = i2c_addr;
              lat_wdata_d = i2c_wdata;
              lat_id_d    = REQ_I2C;
            end
            REQ_MENU: begin
              state_d     = ST_ACCESS;
              lat_we_d    = menu_we;
              lat_addr_d  = menu_addr;
              lat_wdata_d = menu_wdata;
              lat_id_d    = REQ_MENU;
            end
`ifdef RAM_ARB_CLEAR_EN
            REQ_CLEAR: state_d = ST_CLEAR;
`endif
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_ACCESS:    state_d = lat_we_q ? ST_IDLE : ST_READ_WAIT;
      ST_READ_WAIT: state_d = ST_IDLE;
`ifdef RAM_ARB_CLEAR_EN
      ST_CLEAR:     if (clr_last) state_d = ST_IDLE;
`endif
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset so an aborted access shows no ack or write.
  always_comb begin
    ram_addr   = '0;
    ram_din    = '0;
    ram_we     = 1'b0;
    i2c_ack    = 1'b0;
    menu_ack   = 1'b0;
    clear_busy = 1'b0;
    if (state_q == ST_ACCESS) begin
      ram_addr = lat_addr_q;
      ram_din  = lat_wdata_q;
      ram_we   = lat_we_q && reset;
      i2c_ack  = (lat_id_q == REQ_I2C) && reset;
      menu_ack = (lat_id_q == REQ_MENU) && reset;
    end
`ifdef RAM_ARB_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      ram_addr   = clr_addr_q;
      ram_we     = reset;
      clear_busy = 1'b1;
    end
`endif
  end

  assign rd_done_i2c  = (state_q == ST_READ_WAIT) && (lat_id_q == REQ_I2C);
  assign rd_done_menu = (state_q == ST_READ_WAIT) && (lat_id_q == REQ_MENU);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      lat_we_q      <= 1'b0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      lat_id_q      <= REQ_NONE;
      i2c_rvalid_q  <= 1'b0;
      menu_rvalid_q <= 1'b0;
      i2c_rdata_q   <= '0;
      menu_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      lat_we_q      <= lat_we_d;
      lat_addr_q    <= lat_addr_d;
      lat_wdata_q   <= lat_wdata_d;
      lat_id_q      <= lat_id_d;
      i2c_rvalid_q  <= rd_done_i2c;
      menu_rvalid_q <= rd_done_menu;
      if (rd_done_i2c)  i2c_rdata_q  <= ram_dout;
      if (rd_done_menu) menu_rdata_q <= ram_dout;
    end
  end

  assign i2c_rvalid  = i2c_rvalid_q;
  assign menu_rvalid = menu_rvalid_q;
  assign i2c_rdata   = i2c_rdata_q;
  assign menu_rdata  = menu_rdata_q;
  assign dbg_state   = state_q;

endmodule
